// File: rtl/tsu_q_drainer.sv
// Register-bus master that drains the 1588 RX/TX timestamp queues round-robin
// and presents each 128-bit record on a valid/ready stream.
module tsu_q_drainer #(
    parameter logic [7:0]  RX_BASE  = 8'h40,
    parameter logic [7:0]  TX_BASE  = 8'h60,
    parameter int unsigned RD_LAT   = 1,
    parameter logic [7:0]  POLL_GAP = 8'd16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic         wr_out,
    output logic         rd_out,
    output logic [7:0]   addr_out,
    output logic [31:0]  data_out,
    input  logic [31:0]  data_in,
    output logic         ts_valid,
    input  logic         ts_ready,
    output logic [127:0] ts_data,
    output logic         ts_src,
    output logic         busy,
    output logic [15:0]  drain_cnt
);

    typedef enum logic [2:0] {
        IDLE, POLL, POLL_WAIT, POP, DRD, DWAIT, OUT
    } state_t;

    localparam logic [2:0] LAT = RD_LAT[2:0];

    state_t         r_state;
    logic           r_rr;
    logic [7:0]     r_gap;
    logic [1:0]     r_k;
    logic [2:0]     r_wait;
    logic [127:0]   r_ts_data;
    logic           r_ts_src;
    logic [15:0]    r_drain_cnt;

    state_t         w_nxt;
    logic           w_rd;
    logic           w_wr;
    logic [7:0]     w_addr;
    logic [31:0]    w_data;
    logic [7:0]     w_base;
    logic           w_sample;
    logic           w_empty;

    assign w_base   = r_rr ? TX_BASE : RX_BASE;
    assign w_sample = (r_wait == LAT);
    assign w_empty  = (data_in[7:0] == 8'd0);

    always_comb begin
        w_nxt  = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = 8'd0;
        w_data = 32'd0;
        case (r_state)
            IDLE: begin
                if (enable && r_gap == 8'd0)
                    w_nxt = POLL;
            end
            POLL: begin
                w_rd   = 1'b1;
                w_addr = w_base;
                w_nxt  = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (w_sample)
                    w_nxt = w_empty ? IDLE : POP;
            end
            POP: begin
                w_wr   = 1'b1;
                w_addr = w_base + 8'd4;
                w_data = 32'd1;
                w_nxt  = DRD;
            end
            DRD: begin
                w_rd   = 1'b1;
                w_addr = w_base + 8'd8 + {4'd0, r_k, 2'b00};
                w_nxt  = DWAIT;
            end
            DWAIT: begin
                if (w_sample)
                    w_nxt = (r_k == 2'd3) ? OUT : DRD;
            end
            OUT: begin
                if (ts_ready)
                    w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr        <= 1'b0;
            r_gap       <= 8'd0;
            r_k         <= 2'd0;
            r_wait      <= 3'd0;
            r_ts_data   <= 128'd0;
            r_ts_src    <= 1'b0;
            r_drain_cnt <= 16'd0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                IDLE: begin
                    if (r_gap != 8'd0)
                        r_gap <= r_gap - 8'd1;
                end
                POLL: r_wait <= 3'd1;
                POLL_WAIT: begin
                    if (w_sample) begin
                        // An empty poll hands the turn to the other queue after a back-off.
                        if (w_empty) begin
                            r_rr  <= ~r_rr;
                            r_gap <= POLL_GAP;
                        end
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                POP: begin
                    r_k      <= 2'd0;
                    r_ts_src <= r_rr;
                end
                DRD: r_wait <= 3'd1;
                DWAIT: begin
                    if (w_sample) begin
                        case (r_k)
                            2'd0: r_ts_data[127:96] <= data_in;
                            2'd1: r_ts_data[95:64]  <= data_in;
                            2'd2: r_ts_data[63:32]  <= data_in;
                            default: r_ts_data[31:0] <= data_in;
                        endcase
                        if (r_k != 2'd3)
                            r_k <= r_k + 2'd1;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                OUT: begin
                    if (ts_ready) begin
                        r_drain_cnt <= r_drain_cnt + 16'd1;
                        r_rr        <= ~r_rr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_out    = w_rd;
    assign wr_out    = w_wr;
    assign addr_out  = w_addr;
    assign data_out  = w_data;
    assign ts_valid  = (r_state == OUT);
    assign ts_data   = r_ts_data;
    assign ts_src    = r_ts_src;
    assign busy      = (r_state != IDLE);
    assign drain_cnt = r_drain_cnt;

endmodule

// File: tb/tb_tsu_q_drainer.sv
// Directed bench for tsu_q_drainer: a queue-slave model answers the register
// bus with one cycle of read latency; expected values are hand-derived.
module tb_tsu_q_drainer;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         wr_out;
    logic         rd_out;
    logic [7:0]   addr_out;
    logic [31:0]  data_out;
    logic [31:0]  data_in = 32'd0;
    logic         ts_valid;
    logic         ts_ready;
    logic [127:0] ts_data;
    logic         ts_src;
    logic         busy;
    logic [15:0]  drain_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    tsu_q_drainer dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out),
        .data_out(data_out), .data_in(data_in),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
        .ts_src(ts_src), .busy(busy), .drain_cnt(drain_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Queue slave: read data is valid exactly in the cycle after the strobe.
    logic [127:0] rxq[$];
    logic [127:0] txq[$];
    logic [127:0] cur = '0;
    logic         pend = 1'b0;
    logic [31:0]  pval = '0;
    int           nrd = 0, nwr = 0, nval = 0;
    logic         hs_src[$];
    logic [127:0] hs_dat[$];
    int           hs_cyc[$];

    function automatic logic [31:0] rd_val(input logic [7:0] a);
        case (a)
            8'h40: return {24'd0, 8'(rxq.size())};
            8'h60: return {24'd0, 8'(txq.size())};
            8'h48, 8'h68: return cur[127:96];
            8'h4C, 8'h6C: return cur[95:64];
            8'h50, 8'h70: return cur[63:32];
            8'h54, 8'h74: return cur[31:0];
            default: return 32'hBAD0_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        data_in <= pend ? pval : 32'hDEAD_BEEF;
        pend    <= rd_out && rst;
        if (rd_out) begin
            pval <= rd_val(addr_out);
            nrd  <= nrd + 1;
        end
        if (wr_out) begin
            nwr <= nwr + 1;
            if (addr_out == 8'h44 && data_out == 32'd1 && rxq.size() > 0) cur <= rxq.pop_front();
            if (addr_out == 8'h64 && data_out == 32'd1 && txq.size() > 0) cur <= txq.pop_front();
        end
        if (ts_valid) nval <= nval + 1;
        if (ts_valid && ts_ready) begin
            hs_src.push_back(ts_src);
            hs_dat.push_back(ts_data);
            hs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; ts_ready = 1'b0;
        rxq.delete(); txq.delete();
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic wait_rd(input string tag, input int bound, input logic [7:0] exp_a);
        int n = 0;
        while (!rd_out && n < bound) begin
            step(1);
            n++;
        end
        chk({tag, "_seen"}, 128'(rd_out), 128'(1'b1));
        chk({tag, "_addr"}, 128'(addr_out), 128'(exp_a));
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (!ts_valid && n < bound) begin
            step(1);
            n++;
        end
        chk({tag, "_valid"}, 128'(ts_valid), 128'(1'b1));
    endtask

    localparam logic [127:0] REC2 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] REC4 = 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004;
    localparam logic [127:0] REC5 = 128'h55550000_55551111_55552222_55553333;
    localparam logic [127:0] REC6 = 128'h66666666_77777777_88888888_99999999;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, v0, n0, r0, bad;
        logic [127:0] exp_rec[6];

        // Reset state, checked while reset is held
        rst = 1'b0; enable = 1'b0; ts_ready = 1'b0;
        step(1);
        chk("rst_rd",    128'(rd_out),    128'(0));
        chk("rst_wr",    128'(wr_out),    128'(0));
        chk("rst_addr",  128'(addr_out),  128'(0));
        chk("rst_data",  128'(data_out),  128'(0));
        chk("rst_valid", 128'(ts_valid),  128'(0));
        chk("rst_busy",  128'(busy),      128'(0));
        chk("rst_tsdat", ts_data,         128'(0));
        chk("rst_cnt",   128'(drain_cnt), 128'(0));
        rst = 1'b1;
        step(1);

        // Both queues empty: RX poll, then TX poll 19 cycles later
        w0 = nwr; v0 = nval;
        enable = 1'b1;
        wait_rd("t1_poll_rx", 10, 8'h40);
        c0 = cyc;
        step(1);
        wait_rd("t1_poll_tx", 40, 8'h60);
        chk("t1_gap",     128'(cyc - c0),  128'(19));
        chk("t1_no_wr",   128'(nwr - w0),  128'(0));
        chk("t1_novalid", 128'(nval - v0), 128'(0));

        // Single RX record: exact bus timing
        do_reset();
        rxq.push_back(REC2);
        ts_ready = 1'b1; enable = 1'b1;
        wait_rd("t2_poll", 10, 8'h40);
        step(1);
        chk("t2_t1_quiet", 128'({rd_out, wr_out}), 128'(0));
        step(1);
        chk("t2_pop_wr",   128'({wr_out, rd_out}), 128'(2'b10));
        chk("t2_pop_addr", 128'(addr_out), 128'(8'h44));
        chk("t2_pop_data", 128'(data_out), 128'(1));
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("t2_drd_rd",   128'(rd_out),   128'(1));
            chk("t2_drd_addr", 128'(addr_out), 128'(8'h48 + 4 * k));
            step(1);
            chk("t2_dwait_quiet", 128'({rd_out, wr_out, addr_out}), 128'(0));
        end
        step(1);
        chk("t2_valid", 128'(ts_valid), 128'(1));
        chk("t2_data",  ts_data,        REC2);
        chk("t2_src",   128'(ts_src),   128'(0));
        step(1);
        chk("t2_valid_drop", 128'(ts_valid),  128'(0));
        chk("t2_cnt",        128'(drain_cnt), 128'(1));
        chk("t2_idle",       128'(busy),      128'(0));

        // Both queues hold three records: strict alternation, no gap
        do_reset();
        hs_src.delete(); hs_dat.delete(); hs_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            exp_rec[2*i]   = {32'hA0000000 + 32'(i), 32'hA1000000, 32'hA2000000, 32'hA3000000 + 32'(i)};
            exp_rec[2*i+1] = {32'hB0000000 + 32'(i), 32'hB1000000, 32'hB2000000, 32'hB3000000 + 32'(i)};
            rxq.push_back(exp_rec[2*i]);
            txq.push_back(exp_rec[2*i+1]);
        end
        ts_ready = 1'b1; enable = 1'b1;
        begin
            int n = 0;
            while (hs_src.size() < 6 && n < 300) begin
                step(1);
                n++;
            end
        end
        chk("t3_count", 128'(hs_src.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < hs_src.size()) begin
                chk("t3_src",  128'(hs_src[i]), 128'(i % 2));
                chk("t3_data", hs_dat[i],       exp_rec[i]);
                if (i > 0) chk("t3_spacing", 128'(hs_cyc[i] - hs_cyc[i-1]), 128'(13));
            end
        end

        // Backpressure: 20 stalled cycles, accepted on cycle 21
        do_reset();
        rxq.push_back(REC4);
        enable = 1'b1;
        wait_valid("t4", 40);
        n0 = nrd + nwr; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            if (ts_valid !== 1'b1 || ts_data !== REC4 || ts_src !== 1'b0 || rd_out || wr_out) bad++;
            step(1);
        end
        chk("t4_stable",    128'(bad), 128'(0));
        chk("t4_nostrobe",  128'(nrd + nwr - n0), 128'(0));
        chk("t4_c21_valid", 128'(ts_valid), 128'(1));
        ts_ready = 1'b1;
        step(1);
        chk("t4_accepted", 128'(ts_valid),  128'(0));
        chk("t4_cnt",      128'(drain_cnt), 128'(1));

        // enable dropped at POP: record still delivered, then block stays idle
        do_reset();
        rxq.push_back(REC5);
        txq.push_back(REC6);
        ts_ready = 1'b1; enable = 1'b1;
        wait_rd("t5_poll", 10, 8'h40);
        step(2);
        chk("t5_pop", 128'(wr_out), 128'(1));
        enable = 1'b0;
        step(9);
        chk("t5_valid", 128'(ts_valid), 128'(1));
        chk("t5_data",  ts_data,        REC5);
        step(1);
        chk("t5_busy", 128'(busy),      128'(0));
        chk("t5_cnt",  128'(drain_cnt), 128'(1));
        r0 = nrd;
        step(50);
        chk("t5_no_poll",   128'(nrd - r0),     128'(0));
        chk("t5_busy_late", 128'(busy),         128'(0));
        chk("t5_tx_left",   128'(txq.size()),   128'(1));

        // drain_cnt wrap from 0xFFFF
        do_reset();
        rxq.push_back(REC6);
        enable = 1'b1;
        wait_valid("t6", 40);
        force dut.r_drain_cnt = 16'hFFFF;
        step(1);
        release dut.r_drain_cnt;
        step(1);
        chk("t6_preset", 128'(drain_cnt), 128'(16'hFFFF));
        ts_ready = 1'b1;
        step(1);
        chk("t6_wrap", 128'(drain_cnt), 128'(0));

        // Reset during DWAIT k=2 of a TX record
        do_reset();
        txq.push_back(REC4);
        ts_ready = 1'b1; enable = 1'b1;
        wait_rd("t7_poll_rx", 10, 8'h40);
        step(1);
        wait_rd("t7_poll_tx", 40, 8'h60);
        step(8);
        chk("t7_pre_busy", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        chk("t7_busy",  128'(busy),      128'(0));
        chk("t7_strb",  128'({rd_out, wr_out}), 128'(0));
        chk("t7_addr",  128'(addr_out),  128'(0));
        chk("t7_tsdat", ts_data,         128'(0));
        chk("t7_src",   128'(ts_src),    128'(0));
        chk("t7_valid", 128'(ts_valid),  128'(0));
        chk("t7_cnt",   128'(drain_cnt), 128'(0));
        step(1);
        txq.push_back(REC5);
        rst = 1'b1;
        wait_rd("t7_rr_rx", 10, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
